// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes match the ALU controller's multiply-class function decode.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide
// on the {hi,lo} accumulator pair against operand opd.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    shl  = {hi, lo[WIDTH-1]};
    diff = shl - {1'b0, opd};
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      // diff MSB set means the trial subtract went negative: restore
      if (diff[WIDTH]) begin
        hi_n = shl[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative MULT/DIV/MADD/MSUB sequencer owning HI/LO;
// stalls the pipeline on HI/LO access while an op is running.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_n;
  op_e              op_in, op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd, a_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [WIDTH-1:0] quo, rem;
  logic [2*WIDTH-1:0] prod, sprod;
  logic neg_q, rneg_q, dz_q;
  logic sgn_in, div_in, arith_in, div_q, accept;

  assign op_in    = op_e'(Op);
  assign sgn_in   = op_in inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  assign div_in   = op_in inside {OP_DIV, OP_DIVU};
  assign arith_in = !(op_in inside {OP_MTHI, OP_MTLO});
  assign div_q    = op_q inside {OP_DIV, OP_DIVU};
  assign accept   = Start && (state == S_IDLE);

  assign mag_a = (sgn_in && A[WIDTH-1]) ? -A : A;
  assign mag_b = (sgn_in && B[WIDTH-1]) ? -B : B;

  assign Busy  = (state != S_IDLE);
  assign Stall = Busy & (Start | ReadHiLo);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div (div_q),
    .hi     (acc_hi),
    .lo     (acc_lo),
    .opd    (opd),
    .hi_n   (step_hi),
    .lo_n   (step_lo)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept && arith_in)
        state_n = (div_in && B == '0) ? S_FIX : S_RUN;
      S_RUN:  if (cnt == CW'(WIDTH-1))
        state_n = S_FIX;
      S_FIX:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    sprod  = neg_q ? -prod : prod;
    quo    = neg_q ? -acc_lo : acc_lo;
    rem    = rneg_q ? -acc_hi : acc_hi;
    fix_hi = Hi;
    fix_lo = Lo;
    unique case (1'b1)
      dz_q: begin
        fix_hi = a_q;
        fix_lo = '1;
      end
      div_q && !dz_q: begin
        fix_hi = rem;
        fix_lo = quo;
      end
      op_q == OP_MADD:
        {fix_hi, fix_lo} = {Hi, Lo} + sprod;
      op_q == OP_MSUB:
        {fix_hi, fix_lo} = {Hi, Lo} - sprod;
      default:
        {fix_hi, fix_lo} = sprod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Hi     <= '0;
      Lo     <= '0;
      Done   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      a_q    <= '0;
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      Done <= (state == S_FIX);
      unique case (state)
        S_IDLE: if (accept) begin
          unique case (op_in)
            OP_MTHI: Hi <= A;
            OP_MTLO: Lo <= A;
            default: begin
              op_q   <= op_in;
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= div_in ? mag_a : mag_b;
              opd    <= div_in ? mag_b : mag_a;
              a_q    <= A;
              neg_q  <= sgn_in & (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_q <= sgn_in & A[WIDTH-1];
              dz_q   <= div_in && (B == '0);
            end
          endcase
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
        end
        S_FIX: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench: expected {Hi,Lo} queued at issue, checked on Done.
module tb_muldiv_controller;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        ReadHiLo;
  logic        Busy, Stall, Done;
  logic [31:0] Hi, Lo;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int stall_cnt;
  logic [63:0] sb[$];
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_controller #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .A(A), .B(B), .ReadHiLo(ReadHiLo),
    .Busy(Busy), .Stall(Stall), .Done(Done),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(op_e op, logic [31:0] a,
                                        logic [31:0] b,
                                        logic [31:0] hi,
                                        logic [31:0] lo);
    longint sa, sbv, p, q, m;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = sa * sbv;
    r   = {hi, lo};
    case (op)
      OP_MULT:  r = p;
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_MADD:  r = {hi, lo} + p;
      OP_MSUB:  r = {hi, lo} - p;
      OP_DIV, OP_DIVU:
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIV) begin
          q = sa / sbv;
          m = sa % sbv;
          r = {m[31:0], q[31:0]};
        end else r = {a % b, a / b};
      OP_MTHI:  r = {a, lo};
      OP_MTLO:  r = {hi, a};
      default:  r = {hi, lo};
    endcase
    return r;
  endfunction

  always @(negedge Clk) begin
    if (Busy) busy_cnt++;
    if (!Rst && Done) begin
      done_cnt++;
      if (sb.size() == 0) check("done_unexp", {63'b0, Done}, 64'd0);
      else check("hilo", {Hi, Lo}, sb.pop_front());
    end
  end

  // called at a negedge; returns at the negedge after acceptance
  task automatic issue(op_e op, logic [31:0] a, logic [31:0] b);
    int t = 0;
    logic [63:0] e;
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    while (Busy && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 200) check("issue_timeout", 64'd1, 64'd0);
    @(posedge Clk);
    e = model(op, a, b, mhi, mlo);
    {mhi, mlo} = e;
    if (!(op inside {OP_MTHI, OP_MTLO})) sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || Busy) && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 200) check("done_timeout", 64'd1, 64'd0);
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Op = '0;
    A = '0; B = '0; ReadHiLo = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    check("rst_hi", {32'b0, Hi}, 64'd0);
    check("rst_lo", {32'b0, Lo}, 64'd0);
    check("rst_busy", {63'b0, Busy}, 64'd0);
    check("rst_done", {63'b0, Done}, 64'd0);

    busy_cnt = 0; done_cnt = 0;
    issue(OP_MULT, -32'sd3, 32'd5);
    wait_done();
    check("mult_val", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
    check("mult_busy", 64'(busy_cnt), 64'd33);
    check("mult_dones", 64'(done_cnt), 64'd1);

    issue(OP_MULTU, -32'sd3, 32'd5);
    wait_done();
    check("multu_val", {Hi, Lo}, 64'h00000004_FFFFFFF1);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done();
    check("divu_val", {Hi, Lo}, 64'h00000002_0000000E);
    issue(OP_DIV, -32'sd7, 32'd2);
    wait_done();
    check("div_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    check("div_ovf", {Hi, Lo}, 64'h00000000_80000000);

    busy_cnt = 0;
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done();
    check("dz_val", {Hi, Lo}, 64'h00000005_FFFFFFFF);
    check("dz_busy", 64'(busy_cnt), 64'd1);

    issue(OP_MTHI, 32'd1, 32'd0);
    check("mthi", {32'b0, Hi}, 64'd1);
    check("mthi_busy", {63'b0, Busy}, 64'd0);
    issue(OP_MTLO, 32'd2, 32'd0);
    check("mtlo", {32'b0, Lo}, 64'd2);
    issue(OP_MADD, 32'd3, 32'd4);
    wait_done();
    check("madd", {Hi, Lo}, 64'h00000001_0000000E);
    issue(OP_MSUB, 32'd3, 32'd4);
    wait_done();
    check("msub", {Hi, Lo}, 64'h00000001_00000002);

    issue(OP_MULT, 32'd7, 32'd9);
    repeat (9) @(negedge Clk);
    check("rd_nostall_pre", {63'b0, Busy}, 64'd1);
    Start = 1'b1; Op = OP_MTHI; A = 32'h1234; ReadHiLo = 1'b1;
    #1;
    stall_cnt = 0;
    while (Stall && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge Clk);
      #1;
    end
    check("stall_cycles", 64'(stall_cnt), 64'd24);
    check("stall_done", {63'b0, Done}, 64'd1);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    {mhi, mlo} = model(OP_MTHI, 32'h1234, 32'd0, mhi, mlo);
    check("mfhi_new", {32'b0, Hi}, 64'h1234);
    check("lo_keep", {32'b0, Lo}, 64'd63);
    check("idle_nostall", {63'b0, Stall}, 64'd0);
    ReadHiLo = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      issue(op_e'($urandom_range(0, 5)), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom);
      wait_done();
      check("rand_model", {Hi, Lo}, {mhi, mlo});
    end

    done_cnt = 0;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    sb.delete();
    mhi = '0; mlo = '0;
    check("abort_busy", {63'b0, Busy}, 64'd0);
    check("abort_hilo", {Hi, Lo}, 64'd0);
    check("abort_done", {63'b0, Done}, 64'd0);
    repeat (40) @(negedge Clk);
    check("abort_nodone", 64'(done_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Iterative multiply/divide unit with its own sequencing FSM. It owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO issued from the EX stage. It stalls the pipeline when a new HI/LO operation or an MFHI/MFLO read arrives while an operation is still running. It sits beside the ALU, and is driven by the main decoder's multiply opcode class and the ALU controller's function decode.

## Interface
- Clock and reset: one clock, `Clk`. Reset `Rst` is synchronous and active-high.
- Parameters
  - `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- Ports
  - `Clk`  in  1  clock
  - `Rst`  in  1  synchronous active-high reset
  - `Start`  in  1  issue request for `Op`; sampled at the rising edge
  - `Op`  in  3  operation code (encodings in package)
  - `A`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
  - `B`  in  WIDTH  rt operand (divisor / multiplier)
  - `ReadHiLo`  in  1  MFHI/MFLO present in EX this cycle
  - `Busy`  out  1  high whenever the state is not IDLE
  - `Stall`  out  1  combinational; equals `Busy & (Start | ReadHiLo)`
  - `Done`  out  1  one-cycle pulse after HI/LO update from MULT/DIV/MADD/MSUB
  - `Hi`  out  WIDTH  HI register
  - `Lo`  out  WIDTH  LO register

## Operation
- Reset: state IDLE; `Hi`, `Lo`, `Busy`, `Done` and the iteration counter are all 0. `Rst` has priority over every other input. Reset during RUN or FIX aborts the operation with no HI/LO write.
- Start handling
  - `Start` is accepted only in IDLE.
  - `Start` while busy is ignored; `Stall` is high, so the pipeline re-presents the request.
- FSM: IDLE → RUN → FIX → IDLE.
- IDLE, on accepted `Start`:
  - MTHI loads `Hi` ← `A`; MTLO loads `Lo` ← `A`. Both finish at that edge, stay in IDLE and raise no `Done`.
  - MULT, MULTU, MADD and MSUB latch operand magnitudes and a result-sign flag, clear the counter and go to RUN. Signed ops (MULT, MADD, MSUB) use magnitudes; MULTU uses raw operands.
  - DIV and DIVU latch operands the same way. If `B`=0 they go directly to FIX with the divide-by-zero flag set; otherwise they go to RUN.
- RUN: one radix-2 step per cycle for exactly `WIDTH` cycles (counter 0..WIDTH-1), then FIX.
  - Multiply: shift-add into a 2·WIDTH-bit unsigned product.
  - Divide: restoring, on unsigned magnitudes.
- FIX: one cycle. Applies the sign correction and writes HI/LO, then returns to IDLE.
  - MULT/MULTU: {Hi,Lo} ← product, negated if the sign flag is set.
  - MADD: {Hi,Lo} ← {Hi,Lo} + signed product. MSUB: {Hi,Lo} ← {Hi,Lo} − signed product. Arithmetic is modulo 2^(2·WIDTH).
  - DIV/DIVU: Lo ← quotient, Hi ← remainder. For DIV the quotient sign is sign(A)^sign(B) and the remainder takes sign(A).
  - Divide by zero (both signednesses): Lo ← all ones, Hi ← `A`.
- Overflow: DIV of most-negative ÷ −1 gives Lo = most-negative and Hi = 0, with no trap.
- `ReadHiLo` in IDLE gives no stall; `Hi`/`Lo` show the last committed values.

## Timing
- Start accepted at edge E0 (MULT/DIV class):
  - RUN covers edges E1..E32.
  - FIX edge is E33; HI/LO are updated at E33.
  - `Done` is high in the cycle after E33.
  - `Busy` is high from after E0 until E33.
  - Total is 33 cycles busy; a dependent MFHI is stalled 33 cycles.
- Divide by zero: FIX at E1, so `Busy` lasts 1 cycle.
- MTHI/MTLO: 0 busy cycles; the value is visible the cycle after E0.
- Back-to-back ops: a new `Start` in the `Done` cycle is accepted (state is IDLE) with no bubble.
- `Stall` is purely combinational from registered `Busy` and the inputs, with no dependency on `Stall` itself.

## Structure
- Package `muldiv_pkg` holds:
  - `Op` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7
  - FSM state encodings (IDLE, RUN, FIX)
  - the `WIDTH` default
- Sub-module `muldiv_step`: combinational single-iteration shift-add / restore-subtract step, selected by a mul/div flag. The FSM, counter, sign handling and HI/LO registers stay in `muldiv_controller`.

## Test plan
- MULT A=−3, B=5 → after 33 busy cycles Hi=FFFFFFFF, Lo=FFFFFFF1; `Done` pulses once; MULTU same operands → Hi=00000004, Lo=FFFFFFF1.
- DIVU 100/7 → Lo=14, Hi=2. DIV −7/2 → Lo=FFFFFFFD, Hi=FFFFFFFF. DIV 80000000/FFFFFFFF → Lo=80000000, Hi=0.
- DIVU 5/0 → `Busy` for 1 cycle; Lo=FFFFFFFF, Hi=5.
- MTHI 1 then MTLO 2, then MADD 3×4 → {Hi,Lo}=00000001_0000000E. MSUB 3×4 → back to 00000001_00000002.
- `ReadHiLo` and a second `Start` asserted at cycle 10 of a MULT → `Stall` high through E33, second op accepted in the `Done` cycle; MFHI sees the new value.
- `Rst` at cycle 20 of a DIV → next cycle state IDLE, Hi=Lo=0, `Busy`=0, no `Done`.
